// File: rtl/ft_pkg.sv
// ft_pkg: shared types and width defaults for the FTDI sync-FIFO receive path
//   FT_DATA_WIDTH_DEF / FT_BE_WIDTH_DEF : default bus and byte-enable widths
//   ft_state_e                          : receive FSM states
package ft_pkg;
  localparam int FT_DATA_WIDTH_DEF = 32;
  localparam int FT_BE_WIDTH_DEF = FT_DATA_WIDTH_DEF / 8;
  typedef enum logic [1:0] {ST_IDLE, ST_OE, ST_READ} ft_state_e;
endpackage

// File: rtl/ft_skid_buf.sv
// ft_skid_buf: 2-entry FIFO absorbing words read from the FTDI after a stop decision
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i       : store data_i at the tail
//   pop_i        : drop the head (only when count_o != 0)
//   data_o       : current head word
//   count_o      : occupancy, 0..2
module ft_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] mem_q [2];
  logic         wr_q, rd_q;
  logic [1:0]   cnt_q, cnt_d;
  assign cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      wr_q  <= wr_q ^ push_i;
      rd_q  <= rd_q ^ pop_i;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  // The controller stops reading early enough that a third word can never arrive.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !pop_i && cnt_q == 2'd2));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop_i && cnt_q == 2'd0));
endmodule

// File: rtl/ft_rx_ctrl.sv
// ft_rx_ctrl: FTDI FT245-style sync-FIFO receive controller feeding a downstream writer
//   clk_i, rst_i          : FTDI clock, asynchronous active-high reset
//   ft_rxf_n_i            : FTDI has data (active-low)
//   ft_data_i, ft_be_i    : FTDI data bus and byte enables
//   ft_oe_n_o, ft_rd_n_o  : FTDI output enable / read strobe (active-low, registered)
//   data_o, we_o          : word and one-cycle write strobe to downstream
//   full_i, enough_i      : downstream full / almost-full
//   drop_cnt_o            : saturating count of words discarded for partial byte enables
// Optional: define FT_BURST_LIMIT_EN to cap bursts at BURST_MAX words and leave an
// idle slot after each capped burst.
module ft_rx_ctrl
  import ft_pkg::*;
#(
  parameter int FT_DATA_WIDTH = FT_DATA_WIDTH_DEF,
  parameter int FT_BE_WIDTH   = FT_BE_WIDTH_DEF,
  parameter int BURST_MAX     = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     ft_rxf_n_i,
  input  logic [FT_DATA_WIDTH-1:0] ft_data_i,
  input  logic [FT_BE_WIDTH-1:0]   ft_be_i,
  output logic                     ft_oe_n_o,
  output logic                     ft_rd_n_o,
  output logic [FT_DATA_WIDTH-1:0] data_o,
  output logic                     we_o,
  input  logic                     full_i,
  input  logic                     enough_i,
  output logic [15:0]              drop_cnt_o
);
  if (BURST_MAX < 1 || FT_BE_WIDTH * 8 != FT_DATA_WIDTH) begin : g_cfg_err
    $error("ft_rx_ctrl: inconsistent parameters");
  end
  ft_state_e                state_q, state_d;
  logic                     oe_n_q, oe_n_d, rd_n_q, rd_n_d, we_q;
  logic [FT_DATA_WIDTH-1:0] data_q, data_d, head;
  logic [15:0]              drop_q, drop_d;
  logic [1:0]               count;
  logic                     accept, push, pop, go, stop, lim_stop, lim_block;
  // A word moves on every edge the strobe is low while the FTDI still has data.
  assign accept = !rd_n_q && !ft_rxf_n_i;
  assign push   = accept && &ft_be_i;
  assign pop    = !full_i && count != 2'd0;
  assign go     = !ft_rxf_n_i && !enough_i && count == 2'd0 && !lim_block;
  // A held word plus full downstream means the in-flight word fills the last slot.
  assign stop   = ft_rxf_n_i || enough_i || (count != 2'd0 && full_i) || lim_stop;
  assign drop_d = (accept && !(&ft_be_i) && !(&drop_q)) ? drop_q + 16'd1 : drop_q;
  assign data_d = pop ? head : data_q;
`ifdef FT_BURST_LIMIT_EN
  localparam int BW = $clog2(BURST_MAX + 1);
  logic [BW-1:0] burst_q, burst_d;
  logic          hold_q;
  assign lim_stop  = accept && burst_q == BW'(BURST_MAX - 1);
  assign lim_block = hold_q;
  assign burst_d   = (state_q == ST_READ && !stop) ? burst_q + BW'(accept) : '0;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      burst_q <= '0;
      hold_q  <= 1'b0;
    end else begin
      burst_q <= burst_d;
      hold_q  <= state_q == ST_READ && lim_stop;
    end
  end
`else
  assign lim_stop  = 1'b0;
  assign lim_block = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    oe_n_d  = 1'b1;
    rd_n_d  = 1'b1;
    case (state_q)
      ST_IDLE: if (go) begin
        state_d = ST_OE;
        oe_n_d  = 1'b0;
      end
      ST_OE: begin
        state_d = ST_READ;
        oe_n_d  = 1'b0;
        rd_n_d  = 1'b0;
      end
      ST_READ: if (stop) state_d = ST_IDLE;
      else begin
        oe_n_d = 1'b0;
        rd_n_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      oe_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      we_q    <= 1'b0;
      data_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      oe_n_q  <= oe_n_d;
      rd_n_q  <= rd_n_d;
      we_q    <= pop;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end
  ft_skid_buf #(.W(FT_DATA_WIDTH)) u_skid (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .pop_i  (pop),
    .data_i (ft_data_i),
    .data_o (head),
    .count_o(count)
  );
  assign ft_oe_n_o  = oe_n_q;
  assign ft_rd_n_o  = rd_n_q;
  assign we_o       = we_q;
  assign data_o     = data_q;
  assign drop_cnt_o = drop_q;
endmodule

// File: doc/ft_rx_ctrl.md
FT_RX_CTRL -- requirements
Module: ft_rx_ctrl

Interface
REQ-001 SHALL have parameter FT_DATA_WIDTH, default 32, FTDI bus width in bits.
REQ-002 SHALL have parameter FT_BE_WIDTH, default 4, byte-enable width (FT_DATA_WIDTH/8).
REQ-003 SHALL have parameter BURST_MAX, default 256, max words per burst when FT_BURST_LIMIT_EN is defined.
REQ-004 SHALL have port clk_i  in  1  single clock, FTDI sync-FIFO clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port ft_rxf_n_i  in  1  FTDI receive-data-available, active-low.
REQ-007 SHALL have port ft_data_i  in  FT_DATA_WIDTH  FTDI data bus, sampled.
REQ-008 SHALL have port ft_be_i  in  FT_BE_WIDTH  FTDI byte enables, sampled with ft_data_i.
REQ-009 SHALL have port ft_oe_n_o  out  1  FTDI output enable, active-low, registered.
REQ-010 SHALL have port ft_rd_n_o  out  1  FTDI read strobe, active-low, registered.
REQ-011 SHALL have port data_o  out  FT_DATA_WIDTH  word to downstream selector (its data_i).
REQ-012 SHALL have port we_o  out  1  one-cycle write strobe per word, registered.
REQ-013 SHALL have port full_i  in  1  downstream full; no we_o while high.
REQ-014 SHALL have port enough_i  in  1  downstream almost-full; no new reads while high.
REQ-015 SHALL have port drop_cnt_o  out  16  count of words dropped for partial byte enables.

Function
REQ-016 SHALL implement FSM states IDLE, OE, READ.
REQ-017 SHALL go IDLE->OE when ft_rxf_n_i==0, enough_i==0 and skid buffer empty; ft_oe_n_o=0 from next cycle.
REQ-018 SHALL go OE->READ unconditionally after one cycle; ft_rd_n_o=0 from next cycle, ft_oe_n_o held 0.
REQ-019 SHALL accept a word at each edge where ft_rd_n_o==0 and ft_rxf_n_i==0.
REQ-020 SHALL go READ->IDLE (ft_oe_n_o=ft_rd_n_o=1 next cycle) on ft_rxf_n_i==1, or enough_i==1, or (skid count>=1 and full_i==1).
REQ-021 SHALL store accepted words in a 2-entry skid buffer; overflow never occurs given REQ-020 (assertion).
REQ-022 SHALL discard accepted words with ft_be_i != all-ones, incrementing drop_cnt_o, saturating at 16'hFFFF.
REQ-023 SHALL, each cycle full_i==0 and skid non-empty, register head to data_o, pulse we_o=1, pop; else we_o=0, data_o held.
REQ-024 SHALL give latency: word accepted at edge N appears with we_o=1 after edge N+1 when skid empty and full_i==0.
REQ-025 SHALL preserve word order; simultaneous push and pop in one cycle keeps count unchanged.

Reset
REQ-026 SHALL on rst_i: state=IDLE, ft_oe_n_o=1, ft_rd_n_o=1, we_o=0, data_o=0, skid empty, drop_cnt_o=0, burst counter 0.
REQ-027 SHALL on reset mid-burst release ft_oe_n_o/ft_rd_n_o immediately (asynchronous) and lose buffered words.

Configuration
REQ-028 SHALL with FT_BURST_LIMIT_EN defined count words accepted per burst and go READ->IDLE after BURST_MAX-th word, then hold IDLE at least one cycle (TX arbitration slot).
REQ-029 SHALL without FT_BURST_LIMIT_EN have no burst counter; bursts end only per REQ-020.

Structure
REQ-030 SHALL place FSM state enum and FT_DATA_WIDTH/FT_BE_WIDTH defaults in shared package ft_pkg.
REQ-031 SHALL implement the skid buffer as sub-module ft_skid_buf (depth 2, push/pop/count).

Verification
REQ-032 SHALL cover: rxf_n low 8 words 0x1..0x8, full/enough low -> oe_n low cycle 1, rd_n low cycle 2, we_o 8 pulses, data 0x1..0x8 in order.
REQ-033 SHALL cover: enough_i rises during burst word 3 -> rd_n high next cycle, in-flight word buffered, no loss, no new burst until enough_i=0.
REQ-034 SHALL cover: full_i high 5 cycles mid-burst -> burst ends, skid holds <=2, we_o resumes after full_i low, order intact.
REQ-035 SHALL cover: word with ft_be_i=4'h3 -> not forwarded, drop_cnt_o=1.
REQ-036 SHALL cover: FT_BURST_LIMIT_EN, BURST_MAX=4, rxf_n low 10 words -> bursts of 4,4,2 separated by >=1 IDLE cycle.
REQ-037 SHALL cover: rst_i asserted mid-READ -> oe_n/rd_n high same cycle, we_o=0, drop_cnt_o=0.
